// File: rtl/fifo_arb_ctrl.sv
// Circular FIFO controller over a single-write-port reg_file.
// Two producers share the write port under round-robin arbitration.
module fifo_arb_ctrl #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 2,
  parameter int AF_LEVEL   = 3
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req0,
  input  logic [DATA_WIDTH-1:0] wdata0,
  input  logic                  req1,
  input  logic [DATA_WIDTH-1:0] wdata1,
  output logic                  gnt0,
  output logic                  gnt1,
  input  logic                  rd,
  input  logic                  clr_flags,
  output logic                  wr_en,
  output logic [ADDR_WIDTH-1:0] w_addr,
  output logic [ADDR_WIDTH-1:0] r_addr,
  output logic [DATA_WIDTH-1:0] w_data,
  output logic                  full,
  output logic                  empty,
  output logic                  almost_full,
  output logic [ADDR_WIDTH:0]   count,
  output logic                  ovf,
  output logic                  udf
);

  localparam logic [ADDR_WIDTH:0] DEPTH =
    (ADDR_WIDTH+1)'(1) << ADDR_WIDTH;
  localparam logic [ADDR_WIDTH:0] AF =
    (ADDR_WIDTH+1)'(AF_LEVEL);

  logic [ADDR_WIDTH-1:0] w_ptr;
  logic [ADDR_WIDTH-1:0] r_ptr;
  logic                  prio;
  logic                  can_wr;
  logic                  do_rd;

  assign full        = (count == DEPTH);
  assign empty       = (count == '0);
  assign almost_full = (count >= AF);

  assign can_wr = !full && !reset;
  assign gnt0   = can_wr && req0 && (!req1 || !prio);
  assign gnt1   = can_wr && req1 && (!req0 || prio);
  assign wr_en  = gnt0 | gnt1;
  assign do_rd  = rd && !empty;
  assign w_addr = w_ptr;
  assign r_addr = r_ptr;

  always_comb begin
    w_data = '0;
    unique case (1'b1)
      gnt0:    w_data = wdata0;
      gnt1:    w_data = wdata1;
      default: w_data = '0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_ptr <= '0;
      r_ptr <= '0;
      count <= '0;
      prio  <= 1'b0;
      ovf   <= 1'b0;
      udf   <= 1'b0;
    end else begin
      if (wr_en) begin
        w_ptr <= w_ptr + ADDR_WIDTH'(1);
        prio  <= gnt0;
      end
      if (do_rd)
        r_ptr <= r_ptr + ADDR_WIDTH'(1);
      if (wr_en && !do_rd)
        count <= count + (ADDR_WIDTH+1)'(1);
      else if (!wr_en && do_rd)
        count <= count - (ADDR_WIDTH+1)'(1);
      // a set event in the same cycle beats clr_flags
      ovf <= ((req0 | req1) && full) || (ovf && !clr_flags);
      udf <= (rd && empty) || (udf && !clr_flags);
    end
  end

endmodule

// File: tb/tb_fifo_arb_ctrl.sv
// Random + directed bench for fifo_arb_ctrl against a queue model.
// A small array stands in for the attached reg_file.
module tb_fifo_arb_ctrl;

  localparam int DW    = 8;
  localparam int AW    = 2;
  localparam int DEPTH = 4;
  localparam int AFL   = 3;

  logic          clk = 1'b0;
  logic          reset;
  logic          req0, req1, rd, clr_flags;
  logic [DW-1:0] wdata0, wdata1;
  logic          gnt0, gnt1, wr_en;
  logic [AW-1:0] w_addr, r_addr;
  logic [DW-1:0] w_data;
  logic          full, empty, almost_full;
  logic [AW:0]   count;
  logic          ovf, udf;

  logic [DW-1:0] mem [DEPTH];

  fifo_arb_ctrl #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .AF_LEVEL(AFL)
  ) dut (
    .clk(clk), .reset(reset),
    .req0(req0), .wdata0(wdata0),
    .req1(req1), .wdata1(wdata1),
    .gnt0(gnt0), .gnt1(gnt1),
    .rd(rd), .clr_flags(clr_flags),
    .wr_en(wr_en), .w_addr(w_addr),
    .r_addr(r_addr), .w_data(w_data),
    .full(full), .empty(empty),
    .almost_full(almost_full), .count(count),
    .ovf(ovf), .udf(udf)
  );

  always #5 clk = ~clk;

  always @(posedge clk)
    if (wr_en) mem[w_addr] <= w_data;

  int n_chk = 0;
  int n_err = 0;

  logic [DW-1:0] q[$];
  int prio_m = 0;
  bit ovf_m = 0, udf_m = 0;
  int wcnt = 0, rcnt = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h @%0t",
               tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    q.delete();
    prio_m = 0; ovf_m = 0; udf_m = 0;
    wcnt = 0; rcnt = 0;
  endtask

  task automatic step(input bit r0, input logic [DW-1:0] d0,
                      input bit r1, input logic [DW-1:0] d1,
                      input bit rdi, input bit clr, input bit rst,
                      output int g);
    bit full_m, empty_m;
    @(negedge clk);
    req0 = r0; wdata0 = d0;
    req1 = r1; wdata1 = d1;
    rd = rdi; clr_flags = clr; reset = rst;
    #1;
    full_m  = (q.size() == DEPTH);
    empty_m = (q.size() == 0);
    g = -1;
    if (!rst && !full_m) begin
      if (r0 && r1) g = prio_m;
      else if (r0)  g = 0;
      else if (r1)  g = 1;
    end
    chk("gnt0", 32'(gnt0), 32'(g == 0));
    chk("gnt1", 32'(gnt1), 32'(g == 1));
    chk("wr_en", 32'(wr_en), 32'(g >= 0));
    if (g >= 0) begin
      chk("w_data", 32'(w_data), 32'(g == 1 ? d1 : d0));
      chk("w_addr", 32'(w_addr), 32'(wcnt % DEPTH));
    end
    chk("count", 32'(count), 32'(q.size()));
    chk("full", 32'(full), 32'(full_m));
    chk("empty", 32'(empty), 32'(empty_m));
    chk("almost_full", 32'(almost_full), 32'(q.size() >= AFL));
    chk("ovf", 32'(ovf), 32'(ovf_m));
    chk("udf", 32'(udf), 32'(udf_m));
    chk("r_addr", 32'(r_addr), 32'(rcnt % DEPTH));
    if (!empty_m)
      chk("head", 32'(mem[r_addr]), 32'(q[0]));
    @(posedge clk);
    if (rst) model_reset();
    else begin
      if (rdi && !empty_m) begin
        void'(q.pop_front());
        rcnt++;
      end
      if (g >= 0) begin
        q.push_back(g == 1 ? d1 : d0);
        wcnt++;
        prio_m = (g == 0) ? 1 : 0;
      end
      ovf_m = ((r0 | r1) && full_m) || (ovf_m && !clr);
      udf_m = (rdi && empty_m) || (udf_m && !clr);
    end
  endtask

  task automatic s(input bit r0, input logic [DW-1:0] d0,
                   input bit r1, input logic [DW-1:0] d1,
                   input bit rdi, input bit clr, input bit rst);
    int g;
    step(r0, d0, r1, d1, rdi, clr, rst, g);
  endtask

  initial begin
    bit p0, p1;
    logic [DW-1:0] v0, v1;
    int g;
    logic [DW-1:0] seq[4];
    req0 = 0; req1 = 0; rd = 0; clr_flags = 0;
    wdata0 = '0; wdata1 = '0; reset = 1'b1;
    repeat (2) @(posedge clk);
    model_reset();
    s(0, 0, 0, 0, 0, 0, 1);
    repeat (3) s(0, 0, 0, 0, 0, 0, 0);

    // fill from producer 0, then one refused request
    seq[0] = 8'h11; seq[1] = 8'h22;
    seq[2] = 8'h33; seq[3] = 8'h44;
    for (int i = 0; i < 4; i++) s(1, seq[i], 0, 0, 0, 0, 0);
    s(1, 8'h99, 0, 0, 0, 0, 0);
    s(0, 0, 0, 0, 0, 0, 0);

    // wrap: pop 2, push 2, drain
    s(0, 0, 0, 0, 1, 0, 0);
    s(0, 0, 0, 0, 1, 0, 0);
    s(1, 8'h55, 0, 0, 0, 0, 0);
    s(1, 8'h66, 0, 0, 0, 0, 0);
    // full + rd + req: read only
    s(1, 8'h77, 0, 0, 1, 0, 0);
    repeat (4) s(0, 0, 0, 0, 1, 0, 0);
    // empty + rd + req1: udf, word stays
    s(0, 0, 1, 8'h77, 1, 0, 0);
    s(0, 0, 0, 0, 0, 0, 0);

    // alternating grants from reset
    s(0, 0, 0, 0, 0, 1, 1);
    repeat (4) s(1, 8'hA0, 1, 8'hB0, 0, 0, 0);
    // full: refused request with clr, then clr alone
    s(1, 8'hA0, 1, 8'hB0, 0, 0, 0);
    s(1, 8'hA0, 0, 0, 0, 1, 0);
    s(0, 0, 0, 0, 0, 1, 0);
    repeat (2) s(0, 0, 0, 0, 1, 0, 0);
    s(0, 0, 0, 0, 0, 0, 1);
    s(1, 8'hC1, 1, 8'hC2, 0, 0, 0);

    // random traffic; producers hold until granted
    p0 = 0; p1 = 0; v0 = '0; v1 = '0;
    for (int i = 0; i < 800; i++) begin
      if (!p0 && $urandom_range(0, 2) == 0) begin
        p0 = 1; v0 = DW'($urandom);
      end
      if (!p1 && $urandom_range(0, 2) == 0) begin
        p1 = 1; v1 = DW'($urandom);
      end
      step(p0, v0, p1, v1, $urandom_range(0, 2) == 0,
           $urandom_range(0, 9) == 0,
           $urandom_range(0, 49) == 0, g);
      if (g == 0) p0 = 0;
      if (g == 1) p1 = 0;
    end

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_err);
    $finish;
  end

endmodule
